// File: rtl/my9262_if.sv
// my9262_if: start/data handshake from the register block plus the serial pins toward the MY9262
`timescale 1ns/1ps
interface my9262_if;
    logic [15:0] my9262_Data;
    logic        my9262_Start;
    logic        my9262_Dck;
    logic        my9262_Di;
    logic        my9262_Lat;
    logic        my9262_Busy;
    logic        my9262_Overrun;
    modport master (
        output my9262_Data, my9262_Start,
        input  my9262_Dck, my9262_Di, my9262_Lat, my9262_Busy, my9262_Overrun
    );
    modport slave (
        input  my9262_Data, my9262_Start,
        output my9262_Dck, my9262_Di, my9262_Lat, my9262_Busy, my9262_Overrun
    );
endinterface

// File: rtl/my9262_serial_tx.sv
// my9262_serial_tx: shifts 16-bit grayscale words MSB-first on DI/DCK and pulses LAT every WORDS_PER_LATCH words
`timescale 1ns/1ps
module my9262_serial_tx #(
    parameter int CLK_DIV         = 4,
    parameter int WORDS_PER_LATCH = 16,
    parameter int LAT_CYCLES      = 4
) (
    input logic     csi_clk,
    input logic     rsi_reset_n,
    my9262_if.slave bus
);
    localparam int WW   = WORDS_PER_LATCH > 1 ? $clog2(WORDS_PER_LATCH) : 1;
    localparam int DMAX = CLK_DIV > LAT_CYCLES ? CLK_DIV : LAT_CYCLES;
    localparam int DW   = DMAX > 1 ? $clog2(DMAX) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

    state_t          state_q, state_d;
    logic [15:0]     shreg_q, shreg_d;
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic [WW-1:0]   word_cnt_q, word_cnt_d;
    logic [DW-1:0]   div_q, div_d;
    logic            dck_q, dck_d, di_q, di_d, lat_q, lat_d, busy_q, busy_d, ovr_q, ovr_d;
    logic            div_end, lat_end, last_word, word_done;

    assign div_end   = div_q == DW'(CLK_DIV - 1);
    assign lat_end   = div_q == DW'(LAT_CYCLES - 1);
    assign last_word = word_cnt_q == WW'(WORDS_PER_LATCH - 1);
    assign word_done = dck_q && div_end && bit_cnt_q == 4'd0;

    // state and datapath registers; every output comes straight from a flop
    always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
        if (!rsi_reset_n) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
            div_q      <= '0;
            dck_q      <= 1'b0;
            di_q       <= 1'b0;
            lat_q      <= 1'b0;
            busy_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            word_cnt_q <= word_cnt_d;
            div_q      <= div_d;
            dck_q      <= dck_d;
            di_q       <= di_d;
            lat_q      <= lat_d;
            busy_q     <= busy_d;
            ovr_q      <= ovr_d;
        end
    end

    // next state: a word ends after the last high phase, then latch or go idle
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = bus.my9262_Start ? SHIFT : IDLE;
            SHIFT:   state_d = word_done ? (last_word ? LATCH : IDLE) : SHIFT;
            LATCH:   state_d = lat_end ? IDLE : LATCH;
            default: state_d = IDLE;
        endcase
    end

    // next outputs and counters; a start outside IDLE is dropped and flagged sticky
    always_comb begin
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        word_cnt_d = word_cnt_q;
        div_d      = div_q;
        dck_d      = dck_q;
        di_d       = di_q;
        lat_d      = lat_q;
        busy_d     = busy_q;
        ovr_d      = ovr_q | (bus.my9262_Start && state_q != IDLE);
        case (state_q)
            IDLE: if (bus.my9262_Start) begin
                shreg_d   = bus.my9262_Data;
                bit_cnt_d = 4'd15;
                div_d     = '0;
                di_d      = bus.my9262_Data[15];
                dck_d     = 1'b0;
                busy_d    = 1'b1;
            end
            SHIFT: begin
                div_d = div_end ? '0 : div_q + 1'b1;
                if (div_end && !dck_q) dck_d = 1'b1;
                if (div_end && dck_q) begin
                    dck_d = 1'b0;
                    if (bit_cnt_q != 4'd0) begin
                        shreg_d   = shreg_q << 1;
                        bit_cnt_d = bit_cnt_q - 4'd1;
                        di_d      = shreg_q[14];
                    end else begin
                        di_d       = 1'b0;
                        word_cnt_d = last_word ? '0 : word_cnt_q + 1'b1;
                        lat_d      = last_word;
                        busy_d     = last_word;
                    end
                end
            end
            LATCH: begin
                div_d  = lat_end ? '0 : div_q + 1'b1;
                lat_d  = !lat_end;
                busy_d = !lat_end;
            end
            default: ;
        endcase
    end

    assign bus.my9262_Dck     = dck_q;
    assign bus.my9262_Di      = di_q;
    assign bus.my9262_Lat     = lat_q;
    assign bus.my9262_Busy    = busy_q;
    assign bus.my9262_Overrun = ovr_q;
endmodule

// File: tb/tb_my9262_serial_tx.sv
// tb_my9262_serial_tx: directed scoreboard bench for the MY9262 serial transmit engine
`timescale 1ns/1ps
module tb_my9262_serial_tx;
    localparam int C = 4;
    localparam int W = 16;
    localparam int L = 4;

    logic csi_clk = 1'b0;
    logic rsi_reset_n = 1'b0;
    my9262_if bus();

    my9262_serial_tx #(.CLK_DIV(C), .WORDS_PER_LATCH(W), .LAT_CYCLES(L)) dut (
        .csi_clk(csi_clk),
        .rsi_reset_n(rsi_reset_n),
        .bus(bus)
    );

    always #5 csi_clk = ~csi_clk;

    int   checks = 0;
    int   failures = 0;
    int   lat_run = 0;
    int   lat_pulses = 0;
    logic dck_prev = 1'b0;
    logic exp_ovr = 1'b0;
    logic exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one clock: sample at the falling edge, score DI on each DCK rise, measure LAT pulses
    task automatic tick;
        logic b;
        @(negedge csi_clk);
        if (bus.my9262_Dck && !dck_prev) begin
            chk("dck_rise_bit_pending", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                b = exp_q.pop_front();
                chk("di_bit", {31'd0, bus.my9262_Di}, {31'd0, b});
            end
        end
        if (bus.my9262_Lat) lat_run++;
        else if (lat_run != 0) begin
            if (rsi_reset_n) begin
                chk("lat_width", lat_run, L);
                lat_pulses++;
            end
            lat_run = 0;
        end
        dck_prev = bus.my9262_Dck;
    endtask

    task automatic do_reset;
        rsi_reset_n = 1'b0;
        bus.my9262_Start = 1'b0;
        repeat (3) tick;
        chk("reset_outputs", {27'd0, bus.my9262_Dck, bus.my9262_Di, bus.my9262_Lat, bus.my9262_Busy, bus.my9262_Overrun}, 32'd0);
        rsi_reset_n = 1'b1;
        exp_q.delete();
        exp_ovr = 1'b0;
        lat_pulses = 0;
        tick;
    endtask

    task automatic send(input logic [15:0] d, input int exp_busy, input int poke = 0,
                        input logic ps = 1'b0, input logic [15:0] pd = 16'h0);
        int n;
        bus.my9262_Data = d;
        bus.my9262_Start = 1'b1;
        for (int i = 15; i >= 0; i--) exp_q.push_back(d[i]);
        tick;
        bus.my9262_Start = 1'b0;
        chk("start_resp", {29'd0, bus.my9262_Busy, bus.my9262_Dck, bus.my9262_Di}, {29'd0, 1'b1, 1'b0, d[15]});
        n = 1;
        while (bus.my9262_Busy === 1'b1 && n < 2000) begin
            if (n == poke) begin
                bus.my9262_Data = pd;
                bus.my9262_Start = ps;
                if (ps) exp_ovr = 1'b1;
            end
            tick;
            bus.my9262_Start = 1'b0;
            if (bus.my9262_Busy === 1'b1) n++;
        end
        chk("busy_len", n, exp_busy);
        chk("bits_left", exp_q.size(), 0);
        chk("idle_out", {28'd0, bus.my9262_Dck, bus.my9262_Di, bus.my9262_Lat, bus.my9262_Overrun},
            {28'd0, 3'b000, exp_ovr});
        exp_q.delete();
    endtask

    initial begin
        bus.my9262_Data = 16'h0;
        bus.my9262_Start = 1'b0;
        repeat (3) tick;
        chk("in_reset", {27'd0, bus.my9262_Dck, bus.my9262_Di, bus.my9262_Lat, bus.my9262_Busy, bus.my9262_Overrun}, 32'd0);
        rsi_reset_n = 1'b1;
        for (int i = 0; i < 200; i++) begin
            tick;
            chk("idle_200", {27'd0, bus.my9262_Dck, bus.my9262_Di, bus.my9262_Lat, bus.my9262_Busy, bus.my9262_Overrun}, 32'd0);
        end

        send(16'hA5C3, 32 * C);
        chk("single_no_lat", lat_pulses, 0);

        do_reset;
        for (int i = 0; i < 16; i++) begin
            send(16'(i), i == 15 ? 32 * C + L : 32 * C);
            chk("lat_count", lat_pulses, i == 15 ? 1 : 0);
        end
        send(16'd16, 32 * C);
        chk("word17_no_lat", lat_pulses, 1);

        do_reset;
        send(16'h1234, 32 * C, 40, 1'b1, 16'hBEEF);
        send(16'h5555, 32 * C);
        repeat (20) tick;
        chk("ovr_sticky", {31'd0, bus.my9262_Overrun}, 32'd1);
        do_reset;
        chk("ovr_cleared", {31'd0, bus.my9262_Overrun}, 32'd0);

        send(16'h8001, 32 * C, 32 * C, 1'b1, 16'h8001);
        tick;
        chk("busy_fall_start_dropped", {30'd0, bus.my9262_Busy, bus.my9262_Overrun}, {30'd0, 1'b0, 1'b1});

        do_reset;
        send(16'h0001, 32 * C, 20, 1'b0, 16'hFFFF);

        do_reset;
        for (int i = 0; i < 3; i++) send(16'h00F0, 32 * C);
        bus.my9262_Data = 16'hFFFF;
        bus.my9262_Start = 1'b1;
        for (int i = 0; i < 16; i++) exp_q.push_back(1'b1);
        tick;
        bus.my9262_Start = 1'b0;
        repeat (69) tick;
        chk("pre_reset_word", {30'd0, bus.my9262_Busy, bus.my9262_Dck}, {30'd0, 2'b11});
        #2 rsi_reset_n = 1'b0;
        #1 chk("async_word", {28'd0, bus.my9262_Dck, bus.my9262_Di, bus.my9262_Lat, bus.my9262_Busy}, 32'd0);
        repeat (2) tick;
        rsi_reset_n = 1'b1;
        exp_q.delete();
        lat_pulses = 0;
        tick;
        for (int i = 0; i < 16; i++) begin
            send(16'h1000 + 16'(i), i == 15 ? 32 * C + L : 32 * C);
            chk("lat_after_word_reset", lat_pulses, i == 15 ? 1 : 0);
        end

        lat_pulses = 0;
        for (int i = 0; i < 15; i++) send(16'h0A0A, 32 * C);
        bus.my9262_Data = 16'h3C3C;
        bus.my9262_Start = 1'b1;
        for (int i = 15; i >= 0; i--) exp_q.push_back(bus.my9262_Data[i]);
        tick;
        bus.my9262_Start = 1'b0;
        repeat (32 * C + 1) tick;
        chk("in_latch", {30'd0, bus.my9262_Lat, bus.my9262_Busy}, {30'd0, 2'b11});
        #2 rsi_reset_n = 1'b0;
        #1 chk("async_latch", {28'd0, bus.my9262_Dck, bus.my9262_Di, bus.my9262_Lat, bus.my9262_Busy}, 32'd0);
        repeat (2) tick;
        rsi_reset_n = 1'b1;
        exp_q.delete();
        repeat (10) tick;
        chk("no_partial_lat", {31'd0, bus.my9262_Lat}, 32'd0);
        chk("truncated_lat_uncounted", lat_pulses, 0);
        for (int i = 0; i < 16; i++) begin
            send(16'h2000 + 16'(i), i == 15 ? 32 * C + L : 32 * C);
            chk("lat_after_latch_reset", lat_pulses, i == 15 ? 1 : 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/my9262_serial_tx.md
# my9262_serial_tx

Serial transmit engine for the MY9262 LED driver. It sits behind the Avalon-MM register block and consumes that block's `my9262_Data` / `my9262_Start` pair. Each accepted start pulse shifts one 16-bit grayscale word out MSB-first on DI/DCK. After every `WORDS_PER_LATCH` words it issues a LAT pulse so the chip transfers its shift chain to the output latches.

## Interface
Parameters:
- `CLK_DIV`, default 4: `csi_clk` cycles per DCK half-period; legal range ≥1.
- `WORDS_PER_LATCH`, default 16: words shifted between LAT pulses (one per channel); legal range ≥1.
- `LAT_CYCLES`, default 4: LAT high width in `csi_clk` cycles; legal range ≥1.

Ports:
- `csi_clk`, in, 1: system clock; all logic rising-edge.
- `rsi_reset_n`, in, 1: reset, asynchronous, active-low.
- `my9262_Data`, in, 16: word to transmit; sampled only on start acceptance.
- `my9262_Start`, in, 1: one-cycle start request from the register block.
- `my9262_Dck`, out, 1: serial clock to the chip.
- `my9262_Di`, out, 1: serial data to the chip, MSB first.
- `my9262_Lat`, out, 1: latch pulse to the chip.
- `my9262_Busy`, out, 1: high while a word or a latch is in progress.
- `my9262_Overrun`, out, 1: sticky; set when a start arrives while busy.

## Operation
- All outputs are registered. Reset value of every output is 0. Reset also clears the shift register, the bit counter, the word counter and the divider counter.
- States:
  - IDLE: Dck=0, Di=0, Lat=0, Busy=0.
  - SHIFT: DCK low/high phases.
  - LATCH: Lat=1.
- IDLE → SHIFT: when `my9262_Start`=1 at an edge while in IDLE:
  - load shreg with `my9262_Data`; bit_cnt=15; divider=0;
  - Di=Data[15], Dck=0, Busy=1.
- SHIFT, low phase: lasts CLK_DIV cycles; Dck=0; Di holds the current bit.
- SHIFT, high phase: lasts CLK_DIV cycles; Dck=1; Di unchanged, so data is stable across the DCK rising edge.
- End of a high phase with bit_cnt≠0: shift left, bit_cnt−1, Dck=0, Di=next bit, all on the same edge.
- End of a high phase with bit_cnt=0: Dck=0, Di=0, then:
  - if word_cnt=WORDS_PER_LATCH−1: word_cnt=0, go to LATCH;
  - else: word_cnt+1, go to IDLE.
- LATCH: Lat=1 for LAT_CYCLES cycles, then IDLE with Lat=0 and Busy=0.
- Start handling:
  - a start is accepted only when the state is IDLE at the sampling edge;
  - a start seen in SHIFT or LATCH is dropped and sets Overrun on the next edge;
  - Overrun clears only on reset;
  - `my9262_Data` changes outside the acceptance edge have no effect on the word in flight.
- Counter widths: bit_cnt 4 bits; word_cnt ⌈log2(WORDS_PER_LATCH)⌉ bits, minimum 1; divider ⌈log2(max(CLK_DIV,LAT_CYCLES))⌉ bits, minimum 1. The word counter wraps only through the LATCH transition.

## Timing
- Let k be the edge at which a start is accepted, and C=CLK_DIV.
- Busy, Di=Data[15] and Dck=0 are visible from edge k.
- Dck rises at edges k+(2n+1)C and falls at k+(2n+2)C, for n=0..15. Each bit is updated at its DCK falling edge.
- The DCK clock has exactly 16 rising edges per word.
- Word duration is 32·C cycles: Busy=1 from edge k through edge k+32C−1.
  - Without latch: Busy=0 from edge k+32C.
  - With latch: Lat=1 from edge k+32C to k+32C+LAT_CYCLES−1; Lat=0 and Busy=0 at edge k+32C+LAT_CYCLES.
- Earliest re-accept: a start sampled at the first edge where the state is IDLE. A start coincident with the edge at which Busy falls is still treated as busy and is dropped (Overrun).
- Asynchronous reset mid-word or mid-latch:
  - Dck, Di, Lat and Busy drop immediately;
  - word_cnt=0;
  - no partial latch pulse is completed after reset release.

## Test plan
- Reset release, no start → all outputs 0 for 200 cycles.
- Data=16'hA5C3, one start, C=4 → 16 DCK rising edges, bits 1010010111000011 sampled on those edges, Busy high for exactly 128 cycles, no Lat.
- 16 back-to-back words (each start issued the cycle after Busy falls), Data=channel index 0..15 → Lat high 4 cycles only after word 16; the 17th word produces no Lat.
- Start pulsed at cycle 40 of a word in flight → word bits unchanged, Overrun=1 and remains 1 until reset.
- Change Data to 16'hFFFF mid-word after starting with 16'h0001 → DI sequence still 0x0001.
- Assert reset at cycle 70 of a word, and separately during LATCH → all outputs 0 immediately. After release, the next 16 words produce Lat only after the 16th.
